univ_shift_register: RTL

Parametrised universal shift register. It is the successor to the fixed-width SISO/bidirectional shift register and adds:
- WIDTH-generic datapath.
- Parallel load and parallel readout.
- Explicit hold mode.
- A shift counter with a one-cycle word_done pulse, so a serialiser/deserialiser controller can tell when a full word has moved.

It sits between serial links and word-wide datapath logic in the shift-register family.

---
 rtl/univ_shift_register.sv | 102 ++++++++++
 1 files changed

// File: rtl/univ_shift_register.sv
// Universal WIDTH-bit shift register: hold, shift right/left, parallel load, and a word counter.
// Define UNIV_SHIFT_ROTATE_EN to let the rotate input recirculate the outgoing bit on shifts.
module univ_shift_register #(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int unsigned     CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             serial_in,
    input  logic             rotate,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic [CNT_W-1:0] shift_count,
    output logic             word_done
);

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeRight = 2'b01;
    localparam logic [1:0] ModeLeft  = 2'b10;
    localparam logic [1:0] ModeLoad  = 2'b11;

    localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg_d, shift_reg_q;
    logic [CNT_W-1:0] shift_count_d, shift_count_q;
    logic             word_done_d, word_done_q;
    logic             fill_right, fill_left;
    logic             is_shift;

`ifdef UNIV_SHIFT_ROTATE_EN
    always_comb begin
        fill_right = rotate ? shift_reg_q[0] : serial_in;
        fill_left  = rotate ? shift_reg_q[WIDTH-1] : serial_in;
    end
`else
    logic unused_rotate;
    assign unused_rotate = rotate;

    always_comb begin
        fill_right = serial_in;
        fill_left  = serial_in;
    end
`endif

    always_comb begin
        shift_reg_d   = shift_reg_q;
        shift_count_d = shift_count_q;
        word_done_d   = 1'b0;
        is_shift      = 1'b0;
        case (mode)
            ModeHold: begin
                shift_reg_d = shift_reg_q;
            end
            ModeRight: begin
                shift_reg_d = {fill_right, shift_reg_q[WIDTH-1:1]};
                is_shift    = 1'b1;
            end
            ModeLeft: begin
                shift_reg_d = {shift_reg_q[WIDTH-2:0], fill_left};
                is_shift    = 1'b1;
            end
            ModeLoad: begin
                shift_reg_d   = parallel_in;
                shift_count_d = '0;
            end
            default: begin
                shift_reg_d = shift_reg_q;
            end
        endcase

        // The count is direction-agnostic; holds simply pause it.
        if (is_shift) begin
            if (shift_count_q == LastCount) begin
                shift_count_d = '0;
                word_done_d   = 1'b1;
            end else begin
                shift_count_d = shift_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg_q   <= RESET_VALUE;
            shift_count_q <= '0;
            word_done_q   <= 1'b0;
        end else begin
            shift_reg_q   <= shift_reg_d;
            shift_count_q <= shift_count_d;
            word_done_q   <= word_done_d;
        end
    end

    assign parallel_out = shift_reg_q;
    assign serial_out   = (mode == ModeLeft) ? shift_reg_q[WIDTH-1] : shift_reg_q[0];
    assign shift_count  = shift_count_q;
    assign word_done    = word_done_q;

endmodule
